// File: rtl/fft_pingpong_buffer_pkg.sv
// Shared defaults for the FFT ping-pong sample buffer.
package fft_pingpong_buffer_pkg;

   localparam int unsigned DEF_DATA_W = 8;  // {imag,real}, FP4 each
   localparam int unsigned DEF_ADDR_W = 5;  // 32 points per bank
   localparam int unsigned DEF_CNT_W  = 8;  // frame counter width
   localparam int unsigned NUM_BANKS  = 2;

endpackage : fft_pingpong_buffer_pkg

// File: rtl/fft_pingpong_buffer_mem_bank.sv
// One sample bank: DEPTH x DATA_W, one write port, one synchronous read port, no reset.
module fft_pingpong_buffer_mem_bank
   import fft_pingpong_buffer_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] rdata_d;

   // Read register only moves on a request so the last word is held otherwise.
   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = mem_q[raddr];
      end
   end

   // Storage write and read register update.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
      rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule : fft_pingpong_buffer_mem_bank

// File: rtl/fft_pingpong_buffer.sv
// Two-bank ping-pong sample buffer: streamed fill side, random-access process side,
// automatic bank swap when the fill bank is full and the process bank is free.
module fft_pingpong_buffer
   import fft_pingpong_buffer_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              bitrev_en,
   output logic              frame_avail,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              proc_done,
   output logic              proc_bank,
   output logic [CNT_W-1:0]  frame_cnt
);

   localparam logic [ADDR_W-1:0] LAST_IDX = '1;

   function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
      return {<<{a}};
   endfunction

   logic              fill_bank_q, fill_bank_d;
   logic              proc_bank_q, proc_bank_d;
   logic [ADDR_W-1:0] fill_cnt_q,  fill_cnt_d;
   logic              fill_full_q, fill_full_d;
   logic              proc_busy_q, proc_busy_d;
   logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
   logic              rd_valid_q,  rd_valid_d;
   logic              rd_sel_q,    rd_sel_d;
   logic              rd_seen_q,   rd_seen_d;

   logic              accept;
   logic              swap;
   logic              rd_go;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] bank_rdata [NUM_BANKS];

   // Handshake, swap decision and next-state for fill/process control.
   always_comb begin
      fill_bank_d = fill_bank_q;
      proc_bank_d = proc_bank_q;
      fill_cnt_d  = fill_cnt_q;
      fill_full_d = fill_full_q;
      proc_busy_d = proc_busy_q;
      frame_cnt_d = frame_cnt_q;
      rd_sel_d    = rd_sel_q;
      rd_seen_d   = rd_seen_q;

      wr_ready   = !fill_full_q && !rst;
      accept     = wr_valid && wr_ready;
      wr_addr    = bitrev_en ? bitrev(fill_cnt_q) : fill_cnt_q;
      swap       = fill_full_q && (!proc_busy_q || proc_done);
      rd_go      = rd_en && proc_busy_q;
      rd_valid_d = rd_go;

      // accept needs !fill_full and swap needs fill_full, so they never coincide
      if (accept) begin
         fill_cnt_d = fill_cnt_q + ADDR_W'(1);
         if (fill_cnt_q == LAST_IDX) begin
            fill_full_d = 1'b1;
         end
      end

      if (swap) begin
         fill_bank_d = proc_bank_q;
         proc_bank_d = fill_bank_q;
         fill_cnt_d  = '0;
         fill_full_d = 1'b0;
         proc_busy_d = 1'b1;
         frame_cnt_d = frame_cnt_q + CNT_W'(1);
      end else if (proc_done && proc_busy_q) begin
         proc_busy_d = 1'b0;
      end

      // remember which bank answered so the output mux follows the pre-swap bank
      if (rd_go) begin
         rd_sel_d  = proc_bank_q;
         rd_seen_d = 1'b1;
      end
   end

   // Control registers; sample memory is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         fill_bank_q <= 1'b0;
         proc_bank_q <= 1'b1;
         fill_cnt_q  <= '0;
         fill_full_q <= 1'b0;
         proc_busy_q <= 1'b0;
         frame_cnt_q <= '0;
         rd_valid_q  <= 1'b0;
         rd_sel_q    <= 1'b0;
         rd_seen_q   <= 1'b0;
      end else begin
         fill_bank_q <= fill_bank_d;
         proc_bank_q <= proc_bank_d;
         fill_cnt_q  <= fill_cnt_d;
         fill_full_q <= fill_full_d;
         proc_busy_q <= proc_busy_d;
         frame_cnt_q <= frame_cnt_d;
         rd_valid_q  <= rd_valid_d;
         rd_sel_q    <= rd_sel_d;
         rd_seen_q   <= rd_seen_d;
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      fft_pingpong_buffer_mem_bank #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W)
      ) u_bank (
         .clk   (clk),
         .we    (accept && (fill_bank_q == 1'(b))),
         .waddr (wr_addr),
         .wdata (wr_data),
         .re    (rd_go && (proc_bank_q == 1'(b))),
         .raddr (rd_addr),
         .rdata (bank_rdata[b])
      );
   end

   // Output read mux over the bank read registers; zero until the first read after reset.
   always_comb begin
      rd_data = rd_seen_q ? bank_rdata[rd_sel_q] : '0;
   end

   assign rd_valid    = rd_valid_q;
   assign frame_avail = proc_busy_q;
   assign proc_bank   = proc_bank_q;
   assign frame_cnt   = frame_cnt_q;

endmodule : fft_pingpong_buffer
